// File: rtl/session_ctrl.sv
// rtl/session_ctrl.sv - trading session controller: arm, trade with match counting, halt with cooldown.
// Halt causes are prioritised stop > spread limit > trade limit; all outputs are registered.
module session_ctrl #(
   parameter int          MAX_TRADES = 16,
   parameter logic [7:0]  MAX_SPREAD = 8'd20,
   parameter int          COOLDOWN   = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       stop,
   input  logic       price_valid,
   input  logic [7:0] buy_price,
   input  logic [7:0] sell_price,
   input  logic [7:0] spread_now,
   output logic       enable_count,
   output logic       match_signal,
   output logic       halt_signal,
   output logic [7:0] trade_count,
   output logic [1:0] state,
   output logic [1:0] halt_cause
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      TRADE = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [7:0] MAX_T   = 8'(MAX_TRADES);
   localparam logic [7:0] CD_LOAD = 8'(COOLDOWN - 1);

   state_t     cur, nxt;
   logic       arm_q, arm_d;
   logic [7:0] cd_q, cd_d;
   logic [7:0] count_d;
   logic [1:0] cause_d;
   logic       match_d;

   always_comb begin
      nxt     = cur;
      arm_d   = arm_q;
      cd_d    = cd_q;
      count_d = trade_count;
      cause_d = halt_cause;
      match_d = 1'b0;
      case (cur)
         IDLE: begin
            if (start) begin
               nxt     = ARMED;
               arm_d   = 1'b0;
               count_d = 8'd0;
               cause_d = 2'b00;
            end
         end
         ARMED: begin
            // arm_q marks the second fill cycle; TRADE follows it
            if (stop) begin
               nxt     = HALT;
               cause_d = 2'b01;
               cd_d    = CD_LOAD;
               arm_d   = 1'b0;
            end else if (arm_q) begin
               nxt   = TRADE;
               arm_d = 1'b0;
            end else begin
               arm_d = 1'b1;
            end
         end
         TRADE: begin
            if (stop) begin
               nxt     = HALT;
               cause_d = 2'b01;
               cd_d    = CD_LOAD;
            end else if (spread_now > MAX_SPREAD) begin
               nxt     = HALT;
               cause_d = 2'b10;
               cd_d    = CD_LOAD;
            end else if (trade_count == MAX_T) begin
               nxt     = HALT;
               cause_d = 2'b11;
               cd_d    = CD_LOAD;
            end else if (price_valid && (buy_price >= sell_price)) begin
               match_d = 1'b1;
               count_d = (trade_count < MAX_T) ? trade_count + 8'd1 : trade_count;
            end
         end
         HALT: begin
            if (cd_q == 8'd0) begin
               nxt = IDLE;
            end else begin
               cd_d = cd_q - 8'd1;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur          <= IDLE;
         arm_q        <= 1'b0;
         cd_q         <= 8'd0;
         enable_count <= 1'b0;
         match_signal <= 1'b0;
         halt_signal  <= 1'b0;
         trade_count  <= 8'd0;
         halt_cause   <= 2'b00;
      end else begin
         cur          <= nxt;
         arm_q        <= arm_d;
         cd_q         <= cd_d;
         enable_count <= (nxt == ARMED) || (nxt == TRADE);
         match_signal <= match_d;
         halt_signal  <= (nxt == HALT);
         trade_count  <= count_d;
         halt_cause   <= cause_d;
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_session_ctrl.sv
// tb/tb_session_ctrl.sv - self-checking bench for session_ctrl against a cycle-count model.
module tb_session_ctrl;

   localparam int MAX_TRADES = 16;
   localparam int MAX_SPREAD = 20;
   localparam int COOLDOWN   = 8;

   logic       clk = 1'b0;
   logic       reset_n, start, stop, price_valid;
   logic [7:0] buy_price, sell_price, spread_now;
   logic       enable_count, match_signal, halt_signal;
   logic [7:0] trade_count;
   logic [1:0] state, halt_cause;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   session_ctrl #(
      .MAX_TRADES(MAX_TRADES),
      .MAX_SPREAD(8'(MAX_SPREAD)),
      .COOLDOWN(COOLDOWN)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
      .price_valid(price_valid), .buy_price(buy_price), .sell_price(sell_price),
      .spread_now(spread_now), .enable_count(enable_count), .match_signal(match_signal),
      .halt_signal(halt_signal), .trade_count(trade_count), .state(state),
      .halt_cause(halt_cause)
   );

   // Model: phase plus remaining-cycle budgets for the arming and cooldown windows
   int m_phase = 0, m_arm_left = 0, m_halt_left = 0, m_count = 0, m_cause = 0;
   bit m_match = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = 0; m_arm_left = 0; m_halt_left = 0;
         m_count = 0; m_cause = 0; m_match = 1'b0;
      end else begin
         m_match = 1'b0;
         case (m_phase)
            0: if (start) begin
                  m_phase = 1; m_arm_left = 2; m_count = 0; m_cause = 0;
               end
            1: if (stop) begin
                  m_phase = 3; m_halt_left = COOLDOWN; m_cause = 1;
               end else begin
                  m_arm_left--;
                  if (m_arm_left == 0) m_phase = 2;
               end
            2: if (stop) begin
                  m_phase = 3; m_halt_left = COOLDOWN; m_cause = 1;
               end else if (int'(spread_now) > MAX_SPREAD) begin
                  m_phase = 3; m_halt_left = COOLDOWN; m_cause = 2;
               end else if (m_count == MAX_TRADES) begin
                  m_phase = 3; m_halt_left = COOLDOWN; m_cause = 3;
               end else if (price_valid && int'(buy_price) >= int'(sell_price)) begin
                  m_count++; m_match = 1'b1;
               end
            default: begin
               m_halt_left--;
               if (m_halt_left == 0) m_phase = 0;
            end
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("model_state", 32'(state), 32'(m_phase));
         check("model_enable", 32'(enable_count), 32'(m_phase == 1 || m_phase == 2));
         check("model_halt", 32'(halt_signal), 32'(m_phase == 3));
         check("model_match", 32'(match_signal), 32'(m_match));
         check("model_count", 32'(trade_count), 32'(m_count));
         check("model_cause", 32'(halt_cause), 32'(m_cause));
      end
   end

   task automatic drive(input bit s, input bit st, input bit v,
                        input int b, input int se, input int sp);
      start = s; stop = st; price_valid = v;
      buy_price = 8'(b); sell_price = 8'(se); spread_now = 8'(sp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"}, 32'(state), 0);
      check({tag, "_enable"}, 32'(enable_count), 0);
      check({tag, "_match"}, 32'(match_signal), 0);
      check({tag, "_halt"}, 32'(halt_signal), 0);
      check({tag, "_count"}, 32'(trade_count), 0);
      check({tag, "_cause"}, 32'(halt_cause), 0);
   endtask

   task automatic enter_trade();
      drive(1, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      ticks(2);
   endtask

   initial begin
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      ticks(2);
      check_all_zero("reset");
      reset_n = 1'b1;
      check_en = 1'b1;

      ticks(2);
      check("idle_hold", 32'(state), 0);

      // Arming: two ARMED cycles, enable from the first
      drive(1, 0, 0, 0, 0, 0);
      tick();
      check("armed1_state", 32'(state), 1);
      check("armed1_enable", 32'(enable_count), 1);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      check("armed2_state", 32'(state), 1);
      tick();
      check("trade_entry", 32'(state), 2);

      drive(0, 0, 1, 82, 78, 0);
      tick();
      check("match_pulse", 32'(match_signal), 1);
      check("match_count", 32'(trade_count), 1);
      drive(0, 0, 1, 60, 72, 0);
      tick();
      check("nomatch_pulse", 32'(match_signal), 0);
      check("nomatch_count", 32'(trade_count), 1);

      // Spread boundary: equal holds, greater halts
      drive(0, 0, 0, 0, 0, 20);
      tick();
      check("spread_eq_state", 32'(state), 2);
      drive(0, 0, 0, 0, 0, 21);
      tick();
      check("spread_gt_state", 32'(state), 3);
      check("spread_gt_cause", 32'(halt_cause), 2);
      check("spread_gt_enable", 32'(enable_count), 0);
      drive(0, 0, 0, 0, 0, 0);
      ticks(7);
      check("cooldown_last", 32'(state), 3);
      tick();
      check("cooldown_done", 32'(state), 0);
      check("idle_keep_count", 32'(trade_count), 1);
      check("idle_keep_cause", 32'(halt_cause), 2);

      // Trade limit
      drive(1, 0, 0, 0, 0, 0);
      tick();
      check("restart_count", 32'(trade_count), 0);
      check("restart_cause", 32'(halt_cause), 0);
      drive(0, 0, 0, 0, 0, 0);
      ticks(2);
      drive(0, 0, 1, 100, 50, 0);
      ticks(16);
      check("limit_count", 32'(trade_count), 16);
      check("limit_state", 32'(state), 2);
      tick();
      check("limit_halt", 32'(state), 3);
      check("limit_cause", 32'(halt_cause), 3);
      check("limit_sat", 32'(trade_count), 16);

      // Start held through HALT launches on the first IDLE cycle
      drive(1, 0, 0, 0, 0, 0);
      ticks(8);
      check("held_start_idle", 32'(state), 0);
      tick();
      check("held_start_armed", 32'(state), 1);
      check("held_start_count", 32'(trade_count), 0);

      drive(0, 1, 0, 0, 0, 0);
      tick();
      check("armed_stop_state", 32'(state), 3);
      check("armed_stop_cause", 32'(halt_cause), 1);
      drive(0, 0, 0, 0, 0, 0);
      ticks(8);

      drive(0, 1, 0, 0, 0, 0);
      tick();
      check("idle_stop_ignored", 32'(state), 0);

      // Stop beats a simultaneous qualifying match
      enter_trade();
      drive(0, 0, 1, 90, 10, 0);
      tick();
      check("pre_stop_count", 32'(trade_count), 1);
      drive(0, 1, 1, 90, 10, 0);
      tick();
      check("stop_state", 32'(state), 3);
      check("stop_cause", 32'(halt_cause), 1);
      check("stop_match", 32'(match_signal), 0);
      check("stop_count", 32'(trade_count), 1);
      drive(0, 0, 0, 0, 0, 0);
      ticks(8);

      // Asynchronous reset mid-TRADE
      enter_trade();
      drive(0, 0, 1, 100, 50, 0);
      ticks(5);
      check("pre_reset_count", 32'(trade_count), 5);
      drive(0, 0, 0, 0, 0, 0);
      #1 reset_n = 1'b0;
      #1 check_all_zero("async_reset");
      tick();
      reset_n = 1'b1;
      tick();
      check("post_reset_idle", 32'(state), 0);

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
